out_display_driver: RTL
=======================

Name: out_display_driver

Overview:
- Downstream consumer of the 8-bit output register.
- Converts the register's `display` byte to decimal with a sequential double-dabble (shift-add-3) engine.
- Supports unsigned and two's-complement signed interpretation.
- Time-multiplexes the result onto a 4-digit common-cathode 7-segment display: sign, hundreds, tens, ones.

Parameters:
- SCAN_DIV, 4: clock cycles each digit stays enabled; must be ≥1.
- BLANK_LZ, 1: 1 blanks leading zeros in hundreds/tens; 0 always shows them.

Ports:
- clk  input  1  system clock, all state on rising edge.
- clr  input  1  synchronous active-high reset.
- value  input  8  byte from output register.
- signed_mode  input  1  1 = interpret value as two's complement.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- dig_n  output  4  digit enables, active-low one-hot; bit0 = ones, bit1 = tens, bit2 = hundreds, bit3 = sign; registered.
- bcd  output  12  latched result {hundreds, tens, ones}, 4 bits each.
- neg  output  1  latched sign of the displayed value.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (clk edge with clr=1), required register values:
  - state = IDLE, busy = 0, bcd = 12'h000, neg = 0.
  - Shadow value = 8'h00, shadow mode = 0.
  - Scan index = 0, prescaler = 0, seg = 7'h00, dig_n = 4'hF.
  - clr has priority over everything; reset mid-conversion aborts it and does not update bcd/neg.
- FSM states: IDLE, CONV.
- IDLE:
  - Each edge, compare {signed_mode, value} with the shadow.
  - If different: capture both into the shadow and compute the magnitude.
    - mag = value when signed_mode = 0 or value[7] = 0.
    - Otherwise mag = (~value + 1) mod 256; 8'h80 gives mag 128.
  - Load the 20-bit shift register {12'h000, mag}, clear the bit counter, go to CONV.
  - If equal: remain in IDLE.
- CONV:
  - Each edge: for each BCD nibble ≥5 add 3, then shift left 1; increment the counter.
  - On the 8th CONV edge: write bcd = shifted nibbles and neg = sign from the shadow, return to IDLE.
- Latency:
  - Change sampled in IDLE at edge N.
  - busy = 1 after edge N through edge N+8.
  - bcd/neg valid after edge N+8.
- Input changes while busy:
  - Ignored until IDLE.
  - The first IDLE edge re-compares and restarts if the value differs from the shadow.
  - Intermediate values may never be displayed.
- After reset, value 8'h00 with unsigned mode starts no conversion; the display already shows 0.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1.
  - On wrap, the scan index increments modulo 4 (0→1→2→3→0).
  - Every non-reset edge: dig_n = ~(1 << index), and seg = glyph for the digit at the current index.
- Glyphs:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - minus = 40, blank = 00.
- Blanking with BLANK_LZ = 1:
  - Hundreds is blank when 0.
  - Tens is blank when hundreds and tens are both 0.
  - Ones is never blank.
- Sign digit: minus when neg = 1, else blank.
- Nibble values >9 cannot occur and are never produced.
- The display refreshes from latched bcd/neg only; busy does not blank or freeze the scan.

Test Plan:
1. Reset then value=8'h00, signed_mode=0 for 20 cycles -> busy stays 0, bcd=000. With SCAN_DIV=4, sequence is dig_n=1110 with seg=3F; then 1101 and 1011 with seg=00; then 0111 with seg=00; each held 4 cycles.
2. value=8'hFF, signed_mode=0 at edge N -> busy=1 edges N..N+7, bcd=12'h255 and neg=0 after edge N+8. Scan shows 6D, 6D, 5B on ones/tens/hundreds, sign blank.
3. value=8'h80, signed_mode=1 -> bcd=12'h128, neg=1; sign digit seg=40. Then value=8'hF6 -> bcd=12'h010, neg=1, hundreds blank, tens 06, ones 3F.
4. Hold value=8'h07, then toggle signed_mode 0→1 -> a new conversion runs; bcd=12'h007, neg=0 unchanged. value=8'h05 during CONV at edge N+3 -> first result 8'h07 lands at N+8, restart at the next IDLE edge, bcd=12'h005.
5. Assert clr at edge N+4 of a conversion of 8'hC8 -> bcd stays 000, busy=0, dig_n=F. Next clr=0 edge, shadow 00≠C8 -> conversion restarts, bcd=12'h200.
6. BLANK_LZ=0, value=8'h09 -> hundreds and tens show 3F; ones shows 6F.

Source files
------------

// File: rtl/out_display_driver.sv
// Decimal display driver: converts the output-register byte to BCD with a
// sequential double-dabble engine and scans it onto a 4-digit 7-segment display.
module out_display_driver #(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  value,
  input  logic        signed_mode,
  output logic [6:0]  seg,
  output logic [3:0]  dig_n,
  output logic [11:0] bcd,
  output logic        neg,
  output logic        busy
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t         state_q, state_d;
  logic [7:0]     shadow_val;
  logic           shadow_mode;
  logic [19:0]    sr, sr_step;
  logic [2:0]     cnt;
  logic [7:0]     mag;
  logic           changed;
  logic [PW-1:0]  presc;
  logic [1:0]     idx;
  logic [6:0]     glyph_cur;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0: g = 7'h3F;
      4'd1: g = 7'h06;
      4'd2: g = 7'h5B;
      4'd3: g = 7'h4F;
      4'd4: g = 7'h66;
      4'd5: g = 7'h6D;
      4'd6: g = 7'h7D;
      4'd7: g = 7'h07;
      4'd8: g = 7'h7F;
      4'd9: g = 7'h6F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  assign busy = (state_q == CONV);

  always_comb begin
    changed = ({signed_mode, value} != {shadow_mode, shadow_val});
    mag     = (signed_mode && value[7]) ? (~value + 8'd1) : value;
    // add-3 on each BCD nibble, then shift the whole register left by one
    sr_step = sr;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sr[8 + 4*i +: 4] >= 4'd5)
        sr_step[8 + 4*i +: 4] = sr[8 + 4*i +: 4] + 4'd3;
    end
    sr_step = {sr_step[18:0], 1'b0};
    state_d = state_q;
    case (state_q)
      IDLE:    if (changed) state_d = CONV;
      CONV:    if (cnt == 3'd7) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      shadow_val  <= '0;
      shadow_mode <= 1'b0;
      sr          <= '0;
      cnt         <= '0;
      bcd         <= '0;
      neg         <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (changed) begin
            shadow_val  <= value;
            shadow_mode <= signed_mode;
            sr          <= {12'h000, mag};
            cnt         <= '0;
          end
        end
        CONV: begin
          sr  <= sr_step;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            bcd <= sr_step[19:8];
            neg <= shadow_mode & shadow_val[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    glyph_cur = 7'h00;
    case (idx)
      2'd0: glyph_cur = glyph(bcd[3:0]);
      2'd1: glyph_cur = (BLANK_LZ && bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0)
                        ? 7'h00 : glyph(bcd[7:4]);
      2'd2: glyph_cur = (BLANK_LZ && bcd[11:8] == 4'd0) ? 7'h00 : glyph(bcd[11:8]);
      2'd3: glyph_cur = neg ? 7'h40 : 7'h00;
      default: glyph_cur = 7'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      presc <= '0;
      idx   <= '0;
      seg   <= '0;
      dig_n <= '1;
    end else begin
      if (presc == PMAX) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      dig_n <= ~(4'b0001 << idx);
      seg   <= glyph_cur;
    end
  end

endmodule
